// File: rtl/sd_onchip_memory_v2.sv
// Single-port on-chip RAM with an Avalon-MM slave face, byte-enabled writes,
// 1- or 2-cycle read latency, clock-enable pipeline freeze and a post-reset clear engine.
module sd_onchip_memory_v2 #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 10,
   parameter int unsigned READ_LATENCY   = 1,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [ADDR_WIDTH-1:0]   address,
   input  logic [DATA_WIDTH/8-1:0] byteenable,
   input  logic                    chipselect,
   input  logic                    read,
   input  logic                    write,
   input  logic [DATA_WIDTH-1:0]   writedata,
   input  logic                    clken,
   input  logic                    reset_req,
   output logic [DATA_WIDTH-1:0]   readdata,
   output logic                    readdatavalid,
   output logic                    waitrequest,
   output logic                    busy
);

   localparam int unsigned BE_W  = DATA_WIDTH / 8;
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   typedef enum logic {ST_RUN = 1'b0, ST_CLEAR = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
   logic                    clear_active;
   logic                    accept, wr_acc, rd_acc;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
   logic                    v1_q;
   logic [DATA_WIDTH-1:0]   d1_q;
   logic                    out_v;
   logic [DATA_WIDTH-1:0]   out_d;

   // State register and clear address counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // Next state: sweep every word once, leave CLEAR after the last one
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      unique case (state_q)
         ST_CLEAR: begin
            clr_cnt_d = ADDR_WIDTH'(clr_cnt_q + 1'b1);
            if (clr_cnt_q == LAST_ADDR) state_d = ST_RUN;
         end
         ST_RUN: ;
      endcase
   end

   // State decode and access qualification; a read colliding with a write is dropped
   always_comb begin
      clear_active = (state_q == ST_CLEAR);
      waitrequest  = clear_active;
      busy         = clear_active;
      accept       = ~clear_active & chipselect & clken & ~reset_req;
      wr_acc       = accept & write;
      rd_acc       = accept & read & ~write;
   end

   // Array: zeroed by the clear engine, otherwise byte-masked writes; no reset so contents persist
   always_ff @(posedge clk) begin
      if (clear_active) begin
         mem_q[clr_cnt_q] <= '0;
      end else if (wr_acc) begin
         for (int i = 0; i < BE_W; i++) begin
            if (byteenable[i]) mem_q[address][8*i +: 8] <= writedata[8*i +: 8];
         end
      end
   end

   // First read stage; frozen while clken is low
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v1_q <= 1'b0;
         d1_q <= '0;
      end else if (clken) begin
         v1_q <= rd_acc;
         if (rd_acc) d1_q <= mem_q[address];
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic                  v2_q;
      logic [DATA_WIDTH-1:0] d2_q;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            v2_q <= 1'b0;
            d2_q <= '0;
         end else if (clken) begin
            v2_q <= v1_q;
            d2_q <= d1_q;
         end
      end

      assign out_v = v2_q;
      assign out_d = d2_q;
   end else begin : g_lat1
      assign out_v = v1_q;
      assign out_d = d1_q;
   end

   // A result held by clken low is released as soon as clken returns
   assign readdata      = out_d;
   assign readdatavalid = out_v & clken;

endmodule

// File: tb/tb_sd_onchip_memory_v2.sv
// Directed bench for sd_onchip_memory_v2: default build, a 2-cycle-latency build
// and a no-clear build, all driven by the same bus stimulus.
module tb_sd_onchip_memory_v2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [9:0]  address = '0;
   logic [3:0]  byteenable = '0;
   logic        chipselect = 1'b0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [31:0] writedata = '0;
   logic        clken = 1'b1;
   logic        reset_req = 1'b0;

   logic [31:0] rdata1, rdata2, rdata3;
   logic        rdv1, rdv2, rdv3;
   logic        wait1, wait2, wait3;
   logic        busy1, busy2, busy3;

   int checks = 0;
   int errors = 0;
   int n;

   always #5 clk = ~clk;

   sd_onchip_memory_v2 dut (
      .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
      .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
      .clken(clken), .reset_req(reset_req), .readdata(rdata1), .readdatavalid(rdv1),
      .waitrequest(wait1), .busy(busy1));

   sd_onchip_memory_v2 #(.READ_LATENCY(2)) dut_lat2 (
      .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
      .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
      .clken(clken), .reset_req(reset_req), .readdata(rdata2), .readdatavalid(rdv2),
      .waitrequest(wait2), .busy(busy2));

   sd_onchip_memory_v2 #(.CLEAR_ON_RESET(1'b0)) dut_noclr (
      .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
      .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
      .clken(clken), .reset_req(reset_req), .readdata(rdata3), .readdatavalid(rdv3),
      .waitrequest(wait3), .busy(busy3));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2 reset_n = 1'b0;
      #1;
      check("rst_wait1", 32'(wait1), 32'd1);
      check("rst_busy1", 32'(busy1), 32'd1);
      check("rst_rdv1", 32'(rdv1), 32'd0);
      check("rst_rdata1", rdata1, 32'h0);
      check("rst_wait3", 32'(wait3), 32'd0);
      repeat (3) tick();
      reset_n = 1'b1;

      n = 0;
      while (wait1 && n < 2000) begin tick(); n++; end
      check("clear_cycles", 32'(n), 32'd1024);
      check("clear_busy1", 32'(busy1), 32'd0);
      check("clear_wait2", 32'(wait2), 32'd0);

      // Cleared top word
      chipselect = 1'b1; read = 1'b1; address = 10'h3FF;
      tick();
      check("rd3ff_rdv", 32'(rdv1), 32'd1);
      check("rd3ff_data", rdata1, 32'h0);
      chipselect = 1'b0; read = 1'b0;
      tick();
      check("rd3ff_pulse_end", 32'(rdv1), 32'd0);

      // Partial byte write followed immediately by read
      chipselect = 1'b1; write = 1'b1; address = 10'h005; byteenable = 4'h5;
      writedata = 32'hDEADBEEF;
      tick();
      write = 1'b0; read = 1'b1;
      tick();
      check("be_rdv", 32'(rdv1), 32'd1);
      check("be_data", rdata1, 32'h00AD00EF);
      chipselect = 1'b0; read = 1'b0;
      tick();
      check("be_lat2_rdv", 32'(rdv2), 32'd1);
      check("be_lat2_data", rdata2, 32'h00AD00EF);

      // Back-to-back reads, both latencies
      chipselect = 1'b1; write = 1'b1; byteenable = 4'hF;
      address = 10'd1; writedata = 32'h11111111; tick();
      address = 10'd2; writedata = 32'h22222222; tick();
      address = 10'd3; writedata = 32'h33333333; tick();
      write = 1'b0; read = 1'b1; address = 10'd1;
      tick();
      check("b2b_l1_rdv0", 32'(rdv1), 32'd1);
      check("b2b_l1_d0", rdata1, 32'h11111111);
      check("b2b_l2_idle", 32'(rdv2), 32'd0);
      address = 10'd2;
      tick();
      check("b2b_l1_d1", rdata1, 32'h22222222);
      check("b2b_l2_rdv0", 32'(rdv2), 32'd1);
      check("b2b_l2_d0", rdata2, 32'h11111111);
      address = 10'd3;
      tick();
      check("b2b_l1_d2", rdata1, 32'h33333333);
      check("b2b_l2_rdv1", 32'(rdv2), 32'd1);
      check("b2b_l2_d1", rdata2, 32'h22222222);
      chipselect = 1'b0; read = 1'b0;
      tick();
      check("b2b_l1_end", 32'(rdv1), 32'd0);
      check("b2b_l2_rdv2", 32'(rdv2), 32'd1);
      check("b2b_l2_d2", rdata2, 32'h33333333);
      tick();
      check("b2b_l2_end", 32'(rdv2), 32'd0);

      // Read held by clken low for three cycles
      chipselect = 1'b1; read = 1'b1; address = 10'h005;
      tick();
      chipselect = 1'b0; read = 1'b0; clken = 1'b0;
      #1;
      check("ck_low0", 32'(rdv1), 32'd0);
      tick();
      check("ck_low1", 32'(rdv1), 32'd0);
      tick();
      check("ck_low2", 32'(rdv1), 32'd0);
      clken = 1'b1;
      #1;
      check("ck_emit_rdv", 32'(rdv1), 32'd1);
      check("ck_emit_data", rdata1, 32'h00AD00EF);
      tick();
      check("ck_single", 32'(rdv1), 32'd0);
      check("ck_lat2_rdv", 32'(rdv2), 32'd1);
      check("ck_lat2_data", rdata2, 32'h00AD00EF);
      tick();

      // reset_req blocks the write
      reset_req = 1'b1; chipselect = 1'b1; write = 1'b1; address = 10'h020;
      writedata = 32'hAAAA5555;
      tick();
      check("rreq_no_rdv", 32'(rdv1), 32'd0);
      reset_req = 1'b0; write = 1'b0; read = 1'b1;
      tick();
      check("rreq_rdv", 32'(rdv1), 32'd1);
      check("rreq_data", rdata1, 32'h0);
      chipselect = 1'b0; read = 1'b0;
      tick();

      // Simultaneous read+write: write wins, read dropped
      chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 10'h010;
      writedata = 32'h12345678;
      tick();
      check("rw_no_rdv", 32'(rdv1), 32'd0);
      write = 1'b0;
      tick();
      check("rw_rd_rdv", 32'(rdv1), 32'd1);
      check("rw_rd_data", rdata1, 32'h12345678);
      check("rw_lat2_no_rdv", 32'(rdv2), 32'd0);
      chipselect = 1'b0; read = 1'b0;
      tick();

      // Second reset: no-clear build keeps contents, clear build ignores requests
      reset_n = 1'b0;
      #1;
      check("rst2_wait1", 32'(wait1), 32'd1);
      check("rst2_rdv1", 32'(rdv1), 32'd0);
      check("rst2_rdata1", rdata1, 32'h0);
      check("rst2_wait3", 32'(wait3), 32'd0);
      tick();
      reset_n = 1'b1;
      chipselect = 1'b1; read = 1'b1; address = 10'h010;
      tick();
      check("keep_rdv3", 32'(rdv3), 32'd1);
      check("keep_data3", rdata3, 32'h12345678);
      check("clr_ignore_rdv1", 32'(rdv1), 32'd0);
      chipselect = 1'b0; read = 1'b0;
      repeat (500) tick();

      // Reset pulse with address 500 just cleared
      check("mid_wait1", 32'(wait1), 32'd1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_busy1", 32'(busy1), 32'd1);
      check("mid_rst_rdv1", 32'(rdv1), 32'd0);
      tick();
      reset_n = 1'b1;
      n = 0;
      while (wait1 && n < 2000) begin tick(); n++; end
      check("restart_cycles", 32'(n), 32'd1024);
      check("restart_wait2", 32'(wait2), 32'd0);

      chipselect = 1'b1; read = 1'b1; address = 10'h010;
      tick();
      check("post_clr_rdv", 32'(rdv1), 32'd1);
      check("post_clr_data", rdata1, 32'h0);
      chipselect = 1'b0; read = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sd_onchip_memory_v2.md
SD_ONCHIP_MEMORY_V2 -- requirements
Module: sd_onchip_memory_v2

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data bus width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 10: word address width; depth SHALL be 2**ADDR_WIDTH words.
REQ-003 Parameter READ_LATENCY, default 1: cycles from accepted read to readdatavalid; legal values 1 or 2 only.
REQ-004 Parameter CLEAR_ON_RESET, default 1: when 1, the whole array SHALL be zeroed after every reset.
REQ-005 Port clk  in  1: single clock; all logic on its rising edge.
REQ-006 Port reset_n  in  1: asynchronous, active-low reset.
REQ-007 Port address  in  ADDR_WIDTH: word address.
REQ-008 Port byteenable  in  DATA_WIDTH/8: per-byte write enable.
REQ-009 Port chipselect, read, write  in  1 each: Avalon-MM slave qualifiers.
REQ-010 Port writedata  in  DATA_WIDTH: write data.
REQ-011 Port clken  in  1: clock enable; low freezes the access pipeline.
REQ-012 Port reset_req  in  1: high blocks new accesses, as clken low does.
REQ-013 Port readdata  out  DATA_WIDTH: read data, valid only with readdatavalid.
REQ-014 Port readdatavalid  out  1: one-cycle pulse per accepted read.
REQ-015 Port waitrequest  out  1: high while the clear engine runs.
REQ-016 Port busy  out  1: mirrors the clear-engine-active state.

Function
REQ-017 FSM states SHALL be CLEAR and RUN only.
REQ-018 Reset exit SHALL enter CLEAR if CLEAR_ON_RESET=1, else RUN.
REQ-019 CLEAR: one word per cycle, address counter 0..DEPTH-1, all bytes 0, independent of clken/reset_req.
REQ-020 CLEAR->RUN on the cycle after address DEPTH-1 is written; waitrequest/busy deassert that same cycle.
REQ-021 Accept condition: RUN & chipselect & clken & ~reset_req.
REQ-022 Accepted write: update bytes with byteenable[i]=1 only; other bytes unchanged.
REQ-023 Accepted read: readdata = mem[address] exactly READ_LATENCY enabled cycles later, readdatavalid=1 for that one cycle.
REQ-024 read and write both high on an accepted cycle: write performed, read dropped, no readdatavalid.
REQ-025 Read at cycle N+1 to address written at cycle N SHALL return the new data.
REQ-026 clken low: pipeline stages hold; readdatavalid forced 0; a held result emits when clken returns high.
REQ-027 Requests in CLEAR SHALL be ignored (no write, no readdatavalid); master must hold under waitrequest.
REQ-028 Back-to-back reads SHALL sustain one result per cycle with no bubbles.
REQ-029 Address wrap is not applicable: every ADDR_WIDTH value is a valid word.

Reset
REQ-030 reset_n low SHALL asynchronously force readdata=0, readdatavalid=0, pipeline valids=0, clear counter=0.
REQ-031 During reset waitrequest=busy=CLEAR_ON_RESET.
REQ-032 Reset asserted mid-CLEAR SHALL restart clearing from address 0 after release.
REQ-033 Without CLEAR_ON_RESET, array contents SHALL survive reset.

Verification
REQ-034 Reset release, defaults -> waitrequest=1 for exactly 1024 cycles, then 0; read of 0x3FF returns 0x00000000.
REQ-035 Write 0xDEADBEEF to 0x005 with byteenable=0x5 after clear, then read -> readdata=0x00AD00EF one cycle later.
REQ-036 READ_LATENCY=2, reads to 1,2,3 on consecutive cycles -> three consecutive readdatavalid pulses, cycles 2-4, in order.
REQ-037 Read accepted, clken low 3 cycles, then high -> readdatavalid stays 0 while low, single pulse with correct data after.
REQ-038 reset_n pulsed at clear address 500, then released -> clear restarts at 0, waitrequest high for a further 1024 cycles.
REQ-039 read+write same cycle to 0x010 with 0x12345678 -> no readdatavalid; next read of 0x010 returns 0x12345678.
